// File: rtl/stitched_pipeline_rv_if.sv
// Ready/valid stream bundle used on both sides of the stitched pipeline.
//   valid : producer has a word on data
//   ready : consumer takes the word this cycle
//   data  : W-bit payload
// master drives valid/data, slave drives ready.
interface stitched_pipeline_rv_if #(
  parameter int unsigned W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stitched_pipeline_rv.sv
// Parametrised stitched stage chain with ready/valid backpressure, bubble
// collapsing, synchronous flush and an occupancy count.
//   clk       : clock, all state on posedge
//   rst       : synchronous active-high reset (clears valids and data)
//   flush     : drop all in-flight items at the next edge
//   in_if     : slave stream (in_valid / in_ready / in_data)
//   out_if    : master stream (out_valid / out_ready / out_data)
//   occupancy : number of valid pipeline registers
// Stage k adds 2^(k mod W) modulo 2^W. With INPUT_FLOP=1 an extra register
// captures in_data before stage 0.
module stitched_pipeline_rv #(
  parameter int unsigned W          = 32,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned INPUT_FLOP = 1,
  localparam int unsigned SKEW      = (INPUT_FLOP != 0) ? 1 : 0,
  localparam int unsigned R         = NUM_STAGES + SKEW,
  localparam int unsigned OCC_W     = $clog2(R + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  stitched_pipeline_rv_if.slave  in_if,
  stitched_pipeline_rv_if.master out_if,
  output logic [OCC_W-1:0]       occupancy
);

  // Constant added by stage k; the exponent wraps modulo W.
  function automatic logic [W-1:0] stage_add(input int unsigned k);
    return W'(1) << (k % W);
  endfunction

  logic [W-1:0]     data_q [R];
  logic [R-1:0]     v_q;
  logic [W-1:0]     nxt_c  [R];
  logic [R-1:0]     v_d;
  logic [R:0]       rdy_c;
  logic             in_ready_c;
  logic [OCC_W-1:0] occ_d;

  // Ready chain: a register may load if it is empty or its successor moves.
  always_comb begin
    rdy_c    = '0;
    rdy_c[R] = out_if.ready;
    for (int j = int'(R) - 1; j >= 0; j--) begin
      rdy_c[j] = ~v_q[j] | rdy_c[j + 1];
    end
    in_ready_c = rdy_c[0] & ~flush & ~rst;
  end

  // Upstream values per register, next valids and their popcount.
  always_comb begin
    nxt_c = '{default: '0};
    v_d   = '0;
    occ_d = '0;
    nxt_c[0] = (SKEW != 0) ? in_if.data : in_if.data + stage_add(0);
    v_d[0]   = rdy_c[0] ? (in_if.valid & in_ready_c) : v_q[0];
    for (int j = 1; j < int'(R); j++) begin
      nxt_c[j] = data_q[j - 1] + stage_add(unsigned'(j) - SKEW);
      v_d[j]   = rdy_c[j] ? v_q[j - 1] : v_q[j];
    end
    if (rst | flush) begin
      v_d = '0;
    end
    for (int j = 0; j < int'(R); j++) begin
      occ_d = occ_d + OCC_W'(v_d[j]);
    end
  end

  // Pipeline registers; data holds while stalled, valids follow v_d.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < int'(R); j++) begin
        data_q[j] <= '0;
      end
      v_q       <= '0;
      occupancy <= '0;
    end else begin
      for (int j = 0; j < int'(R); j++) begin
        if (rdy_c[j]) begin
          data_q[j] <= nxt_c[j];
        end
      end
      v_q       <= v_d;
      occupancy <= occ_d;
    end
  end

  assign in_if.ready  = in_ready_c;
  assign out_if.valid = v_q[R - 1];
  assign out_if.data  = data_q[R - 1];

endmodule

// File: tb/tb_stitched_pipeline_rv.sv
// Self-checking bench for stitched_pipeline_rv: fixed vector tables, directed
// backpressure / bubble / flush / reset sequences, and random traffic scored
// against a queue model of in-flight items.
module tb_stitched_pipeline_rv;
  localparam int unsigned WA = 32, NA = 2, FA = 1;
  localparam int unsigned RA = NA + FA;
  localparam int unsigned OA = $clog2(RA + 1);
  localparam int unsigned WB = 8, NB = 3, FB = 0;
  localparam int unsigned RB = NB;
  localparam int unsigned OB = $clog2(RB + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, flush_a, rst_b, flush_b;
  logic [OA-1:0] occ_a;
  logic [OB-1:0] occ_b;

  stitched_pipeline_rv_if #(.W(WA)) a_in ();
  stitched_pipeline_rv_if #(.W(WA)) a_out ();
  stitched_pipeline_rv_if #(.W(WB)) b_in ();
  stitched_pipeline_rv_if #(.W(WB)) b_out ();

  stitched_pipeline_rv #(.W(WA), .NUM_STAGES(NA), .INPUT_FLOP(FA)) dut_a (
    .clk(clk), .rst(rst_a), .flush(flush_a),
    .in_if(a_in), .out_if(a_out), .occupancy(occ_a)
  );

  stitched_pipeline_rv #(.W(WB), .NUM_STAGES(NB), .INPUT_FLOP(FB)) dut_b (
    .clk(clk), .rst(rst_b), .flush(flush_b),
    .in_if(b_in), .out_if(b_out), .occupancy(occ_b)
  );

  typedef struct {
    bit          sel;
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;

  vec_t        vecs [$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] q_a [$];
  logic [7:0]  q_b [$];
  bit          acc, popped;
  int          pops;
  logic [31:0] last_pop;
  int          idx, acc_n;

  // Total added by n stages of width w: sum of 2^(k mod w), modulo 2^w.
  function automatic longint unsigned stage_sum(input int unsigned n, input int unsigned w);
    longint unsigned s = 0;
    for (int unsigned k = 0; k < n; k++) s += 64'd1 << (k % w);
    return s % (64'd1 << w);
  endfunction

  function automatic logic [31:0] f_a(input logic [31:0] x);
    return 32'(64'(x) + stage_sum(NA, WA));
  endfunction

  function automatic logic [7:0] f_b(input logic [7:0] x);
    return 8'(64'(x) + stage_sum(NB, WB));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: output handshake with no item outstanding", name);
  endtask

  // One cycle on DUT A, scored against the queue of outstanding results.
  task automatic step_a(input bit iv, input logic [31:0] d, input bit ordy,
                        input bit fl, input bit rs);
    bit exp_rdy;
    a_in.valid = iv; a_in.data = d; a_out.ready = ordy; flush_a = fl; rst_a = rs;
    @(negedge clk);
    exp_rdy = !rs && !fl && !(q_a.size() == int'(RA) && !ordy);
    chk("a_in_ready", a_in.ready, exp_rdy);
    popped = 0;
    if (a_out.valid && ordy) begin
      popped = 1; pops++; last_pop = a_out.data;
      if (q_a.size() == 0) fail_now("a_spurious_out");
      else chk("a_out_data", a_out.data, q_a.pop_front());
    end
    acc = iv && exp_rdy;
    if (acc) q_a.push_back(f_a(d));
    if (rs || fl) q_a.delete();
    @(posedge clk); #1;
    chk("a_occupancy", occ_a, q_a.size());
    if (q_a.size() == 0) chk("a_out_valid_empty", a_out.valid, 0);
    if (rs) chk("a_out_data_reset", a_out.data, 0);
  endtask

  task automatic step_b(input bit iv, input logic [7:0] d, input bit ordy, input bit rs);
    bit exp_rdy;
    b_in.valid = iv; b_in.data = d; b_out.ready = ordy; flush_b = 0; rst_b = rs;
    @(negedge clk);
    exp_rdy = !rs && !(q_b.size() == int'(RB) && !ordy);
    chk("b_in_ready", b_in.ready, exp_rdy);
    popped = 0;
    if (b_out.valid && ordy) begin
      popped = 1; pops++;
      if (q_b.size() == 0) fail_now("b_spurious_out");
      else chk("b_out_data", b_out.data, q_b.pop_front());
    end
    acc = iv && exp_rdy;
    if (acc) q_b.push_back(f_b(d));
    if (rs) q_b.delete();
    @(posedge clk); #1;
    chk("b_occupancy", occ_b, q_b.size());
  endtask

  // Back-to-back table entries from an empty pipe; each result is due 3 cycles later.
  task automatic run_table(input bit sel);
    vec_t v [$];
    int n;
    logic ov, ir;
    logic [31:0] od;
    foreach (vecs[i]) if (vecs[i].sel == sel) v.push_back(vecs[i]);
    n = v.size();
    for (int c = 0; c < n + 3; c++) begin
      if (!sel) begin
        a_in.valid = (c < n); a_in.data = '0; a_out.ready = 1; rst_a = 0; flush_a = 0;
        if (c < n) a_in.data = v[c].din;
      end else begin
        b_in.valid = (c < n); b_in.data = '0; b_out.ready = 1; rst_b = 0; flush_b = 0;
        if (c < n) b_in.data = v[c].din[7:0];
      end
      @(negedge clk);
      ov = sel ? b_out.valid : a_out.valid;
      od = sel ? 32'(b_out.data) : a_out.data;
      ir = sel ? b_in.ready : a_in.ready;
      if (c < n) chk("tbl_in_ready", ir, 1);
      if (c >= 3) begin
        chk("tbl_out_valid", ov, 1);
        chk("tbl_out_data", od, v[c - 3].dout);
      end else begin
        chk("tbl_out_idle", ov, 0);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    a_in.valid = 0; a_in.data = '0; a_out.ready = 0; rst_a = 1; flush_a = 0;
    b_in.valid = 0; b_in.data = '0; b_out.ready = 0; rst_b = 1; flush_b = 0;
    vecs.push_back('{1'b0, 32'd5, 32'd8});
    vecs.push_back('{1'b0, 32'd0, 32'd3});
    vecs.push_back('{1'b0, 32'd1, 32'd4});
    vecs.push_back('{1'b0, 32'd2, 32'd5});
    vecs.push_back('{1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{1'b0, 32'hFFFF_FFFD, 32'h0000_0000});
    vecs.push_back('{1'b1, 32'hF9, 32'h00});
    vecs.push_back('{1'b1, 32'h10, 32'h17});
    vecs.push_back('{1'b1, 32'hFF, 32'h06});
    vecs.push_back('{1'b1, 32'h80, 32'h87});
    #1;

    // Reset state (A)
    step_a(0, 0, 0, 0, 1);
    step_a(0, 0, 1, 0, 1);
    run_table(0);

    // Backpressure: exactly three accepted, then ordered gap-free drain
    step_a(0, 0, 0, 0, 1);
    idx = 10; acc_n = 0;
    for (int c = 0; c < 6; c++) begin
      step_a(1, 32'(idx), 0, 0, 0);
      if (acc) begin idx++; acc_n++; end
    end
    chk("bp_accepted", acc_n, 3);
    chk("bp_occupancy", occ_a, 3);
    for (int c = 0; c < 4; c++) begin
      step_a(idx <= 13, 32'(idx), 1, 0, 0);
      if (acc) idx++;
      chk("bp_no_gap", popped, 1);
      chk("bp_order", last_pop, 32'(13 + c));
    end

    // Bubble collapse: lone stalled item at the tail, two more accepted
    step_a(0, 0, 0, 0, 1);
    step_a(1, 32'h20, 0, 0, 0);
    step_a(0, 0, 0, 0, 0);
    step_a(0, 0, 0, 0, 0);
    chk("bubble_tail_valid", a_out.valid, 1);
    step_a(1, 32'h21, 0, 0, 0);
    step_a(1, 32'h22, 0, 0, 0);
    chk("bubble_occupancy", occ_a, 3);
    for (int c = 0; c < 4; c++) step_a(0, 0, 1, 0, 0);

    // Flush with an input offered, then refill and reset mid-operation
    step_a(1, 32'h30, 0, 0, 0);
    step_a(1, 32'h31, 0, 0, 0);
    step_a(1, 32'h32, 0, 0, 0);
    step_a(1, 32'h33, 0, 1, 0);
    chk("flush_occupancy", occ_a, 0);
    chk("flush_out_valid", a_out.valid, 0);
    for (int c = 0; c < 4; c++) step_a(0, 0, 1, 0, 0);
    step_a(1, 32'h40, 0, 0, 0);
    step_a(1, 32'h41, 0, 0, 0);
    step_a(1, 32'h42, 0, 0, 0);
    step_a(0, 0, 0, 0, 1);
    chk("rst_occupancy", occ_a, 0);
    pops = 0;
    step_a(1, 32'd7, 1, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      step_a(0, 0, 1, 0, 0);
      chk("post_rst_latency", popped, c == 3);
    end
    chk("post_rst_count", pops, 1);
    chk("post_rst_data", last_pop, 32'd10);

    // Random traffic with occasional flush / reset
    for (int c = 0; c < 400; c++) begin
      step_a($urandom_range(0, 3) != 0, 32'($urandom), $urandom_range(0, 3) != 0,
             $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    end
    for (int c = 0; c < RA + 3; c++) step_a(0, 0, 1, 0, 0);
    chk("a_drained", q_a.size(), 0);

    // Config B: W=8, 3 stages, no input flop
    step_b(0, 0, 0, 1);
    step_b(0, 0, 1, 1);
    chk("b_reset_out_valid", b_out.valid, 0);
    chk("b_reset_out_data", b_out.data, 0);
    run_table(1);
    pops = 0; idx = 0;
    for (int c = 0; c < 60 && pops < 6; c++) begin
      step_b(idx < 6, 8'($urandom), (c % 2) == 0, 0);
      if (acc) idx++;
    end
    chk("b_toggle_count", pops, 6);
    chk("b_toggle_empty", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
